// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: byte width,
// arbiter state encoding and a small index helper.
package uart_pkg;

   localparam int BYTE_W = 8;

   localparam logic [0:0] ARB_IDLE   = 1'b0;
   localparam logic [0:0] ARB_LOCKED = 1'b1;

   // Successor of idx in a ring of n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req found searching
// upward from ptr with wrap-around.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] win
);

   // Scanning from the far end lets the closest candidate to ptr overwrite the rest.
   always_comb begin
      int idx;
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            any = 1'b1;
            win = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit port among
// NUM_REQ byte streams, with an idle watchdog for stalled owners.
//
// Handshake: a byte moves on any cycle where valid && ready are both high;
// the producer holds data/last stable while valid is high and not yet ready.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      timeout_evt,
   output logic [0:0]                arb_state
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;
   localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

   logic [0:0]    state;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptr;
   logic [CW-1:0] idle_cnt;

   logic          pick_any;
   logic [PW-1:0] pick_win;
   logic          locked;
   logic          owner_valid;
   logic          owner_last;
   logic          xfer;
   logic          wd_fire;

   rr_pick #(.N(NUM_REQ), .IW(PW)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .any (pick_any),
      .win (pick_win)
   );

   assign locked      = (state == ARB_LOCKED);
   assign owner_valid = locked & req_valid[owner];
   assign owner_last  = req_last[owner];
   assign xfer        = owner_valid & tx_ready;
   assign wd_fire     = (IDLE_TIMEOUT > 0) && locked && !req_valid[owner] && (idle_cnt == CNT_LAST);
   assign arb_state   = state;

   // Pass-through of the owner; nothing is forwarded while arbitrating.
   always_comb begin
      tx_data   = '0;
      tx_valid  = 1'b0;
      req_ready = '0;
      if (locked) begin
         tx_data  = req_data[int'(owner)*BYTE_W +: BYTE_W];
         tx_valid = owner_valid;
         if (tx_ready) begin
            req_ready = grant;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ARB_IDLE;
         grant       <= '0;
         owner       <= '0;
         ptr         <= '0;
         idle_cnt    <= '0;
         timeout_evt <= 1'b0;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state    <= ARB_LOCKED;
                  grant    <= NUM_REQ'(1) << pick_win;
                  owner    <= pick_win;
                  ptr      <= (pick_win == IDX_LAST) ? '0 : pick_win + PW'(1);
                  idle_cnt <= '0;
               end
            end
            ARB_LOCKED: begin
               if (xfer && owner_last) begin
                  state    <= ARB_IDLE;
                  grant    <= '0;
                  idle_cnt <= '0;
               end else if (wd_fire) begin
                  // Forced release leaves ptr alone; the stalled owner re-arbitrates later.
                  state       <= ARB_IDLE;
                  grant       <= '0;
                  idle_cnt    <= '0;
                  timeout_evt <= 1'b1;
               end else if (req_valid[owner]) begin
                  idle_cnt <= '0;
               end else if (IDLE_TIMEOUT > 0) begin
                  idle_cnt <= idle_cnt + CW'(1);
               end
            end
            default: begin
               state <= ARB_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed stimulus for uart_tx_arbiter with a per-requester
// expected-byte scoreboard and a packet-level arbitration reference model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int TO = 16;
   localparam int W  = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [W*NR-1:0] req_data  = '0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_last  = '0;
   logic [NR-1:0]   req_ready;
   logic [W-1:0]    tx_data;
   logic            tx_valid;
   logic            tx_ready  = 1'b0;
   logic [NR-1:0]   grant;
   logic            timeout_evt;
   logic [0:0]      arb_state;

   uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_data    (req_data),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .grant       (grant),
      .timeout_evt (timeout_evt),
      .arb_state   (arb_state)
   );

   int tests = 0;
   int fails = 0;

   // pending stimulus per requester: {gap[5:0], last, data}
   logic [14:0]  pend_q [NR][$];
   logic [W-1:0] exp_q  [NR][$];
   bit           cur_valid [NR];
   int           gap_cnt [NR];
   bit           acc [NR];
   int           ready_mode = 0;
   int           to_seen = 0;

   // reference model state
   bit m_locked = 1'b0;
   int m_owner  = 0;
   int m_ptr    = 0;
   int m_idle   = 0;
   bit m_pulse  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- driver ----------------
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         for (int k = 0; k < NR; k++) begin
            cur_valid[k] = 1'b0;
            gap_cnt[k]   = 0;
            pend_q[k].delete();
            exp_q[k].delete();
         end
         req_valid = '0;
         req_last  = '0;
         tx_ready  = 1'b0;
      end else begin
         for (int k = 0; k < NR; k++) begin
            if (cur_valid[k] && acc[k]) begin
               cur_valid[k] = 1'b0;
               req_valid[k] = 1'b0;
               req_last[k]  = 1'b0;
            end
            if (!cur_valid[k] && pend_q[k].size() > 0) begin
               if (gap_cnt[k] < int'(pend_q[k][0][14:9])) begin
                  gap_cnt[k]++;
               end else begin
                  logic [14:0] e;
                  e = pend_q[k].pop_front();
                  gap_cnt[k]          = 0;
                  cur_valid[k]        = 1'b1;
                  req_valid[k]        = 1'b1;
                  req_last[k]         = e[8];
                  req_data[k*W +: W]  = e[7:0];
                  exp_q[k].push_back(e[7:0]);
               end
            end
         end
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 9) < 7);
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard / model ----------------
   always @(negedge clk) begin
      if (!reset_n) begin
         m_locked = 1'b0;
         m_owner  = 0;
         m_ptr    = 0;
         m_idle   = 0;
         m_pulse  = 1'b0;
         for (int k = 0; k < NR; k++) acc[k] = 1'b0;
      end else begin
         logic [NR-1:0] exp_grant;
         bit found;
         int win;
         exp_grant = m_locked ? NR'(1 << m_owner) : '0;
         check("grant", grant, exp_grant);
         check("tx_valid", tx_valid, m_locked && req_valid[m_owner]);
         check("req_ready", req_ready, (m_locked && tx_ready) ? exp_grant : '0);
         check("timeout_evt", timeout_evt, m_pulse);
         if (timeout_evt) to_seen++;
         for (int k = 0; k < NR; k++) acc[k] = req_valid[k] && req_ready[k];

         if (tx_valid && tx_ready) begin
            if (!m_locked || exp_q[m_owner].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_byte: unexpected byte %0h (model owner %0d locked %0d) at %0t",
                        tx_data, m_owner, m_locked, $time);
            end else begin
               check("tx_data", tx_data, exp_q[m_owner].pop_front());
            end
         end

         m_pulse = 1'b0;
         if (!m_locked) begin
            found = 1'b0;
            win   = 0;
            for (int i = 0; i < NR; i++) begin
               if (!found && req_valid[(m_ptr + i) % NR]) begin
                  found = 1'b1;
                  win   = (m_ptr + i) % NR;
               end
            end
            if (found) begin
               m_locked = 1'b1;
               m_owner  = win;
               m_ptr    = (win + 1) % NR;
               m_idle   = 0;
            end
         end else if (req_valid[m_owner]) begin
            m_idle = 0;
            if (tx_ready && req_last[m_owner]) m_locked = 1'b0;
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_locked = 1'b0;
               m_pulse  = 1'b1;
               m_idle   = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_byte(input int k, input logic [7:0] d, input bit last, input int gap);
      logic [5:0] g;
      g = 6'(gap);
      pend_q[k].push_back({g, last, d});
   endtask

   task automatic push_rand_pkt(input int k, input int len, input bit allow_long);
      for (int i = 0; i < len; i++) begin
         int g;
         g = (allow_long && i > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(17, 40) : $urandom_range(0, 2);
         push_byte(k, 8'($urandom_range(0, 255)), (i == len - 1), g);
      end
   endtask

   function automatic bit busy();
      bit b;
      b = m_locked;
      for (int k = 0; k < NR; k++) begin
         if (pend_q[k].size() > 0 || exp_q[k].size() > 0 || cur_valid[k]) b = 1'b1;
      end
      return b;
   endfunction

   task automatic drain(input string name);
      int n;
      n = 0;
      while (busy() && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      check(name, (n >= 3000), 0);
   endtask

   // ---------------- sequence ----------------
   int t0;

   initial begin
      ready_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_timeout", timeout_evt, 0);
      check("rst_state", arb_state, 0);
      @(posedge clk);
      #2 reset_n = 1'b1;

      // "151>" from requester 1
      t0 = to_seen;
      push_byte(1, 8'h31, 1'b0, 0);
      push_byte(1, 8'h35, 1'b0, 0);
      push_byte(1, 8'h31, 1'b0, 0);
      push_byte(1, 8'h3e, 1'b1, 0);
      drain("t1_drain");
      check("t1_timeouts", to_seen - t0, 0);

      // simultaneous 2-byte packets from requesters 0 and 2
      push_byte(0, 8'h10, 1'b0, 0);
      push_byte(0, 8'h11, 1'b1, 0);
      push_byte(2, 8'h20, 1'b0, 0);
      push_byte(2, 8'h21, 1'b1, 0);
      drain("t2_drain");

      // requester 3 streaming, requester 1 joins once
      for (int p = 0; p < 3; p++) begin
         push_byte(3, 8'h30 + 8'(p), 1'b0, 0);
         push_byte(3, 8'h40 + 8'(p), 1'b0, 0);
         push_byte(3, 8'h50 + 8'(p), 1'b1, 0);
      end
      repeat (3) @(posedge clk);
      push_byte(1, 8'h61, 1'b0, 0);
      push_byte(1, 8'h62, 1'b1, 0);
      drain("t3_drain");

      // requester 2 stalls mid-packet; requester 0 waiting
      t0 = to_seen;
      push_byte(2, 8'ha0, 1'b0, 0);
      push_byte(2, 8'ha1, 1'b1, 30);
      push_byte(0, 8'hb0, 1'b0, 5);
      push_byte(0, 8'hb1, 1'b1, 0);
      drain("t4_drain");
      check("t4_timeout_count", to_seen - t0, 1);

      // UART backpressure is not a stall
      t0 = to_seen;
      ready_mode = 2;
      push_byte(0, 8'hc0, 1'b0, 0);
      push_byte(0, 8'hc1, 1'b1, 0);
      repeat (100) @(posedge clk);
      ready_mode = 0;
      drain("t5_drain");
      check("t5_timeout_count", to_seen - t0, 0);

      // asynchronous reset mid-packet
      ready_mode = 1;
      for (int i = 0; i < 8; i++) push_byte(1, 8'hd0 + 8'(i), (i == 7), 0);
      repeat (4) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("t6_async_grant", grant, 0);
      check("t6_async_req_ready", req_ready, 0);
      check("t6_async_tx_valid", tx_valid, 0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      ready_mode = 0;
      push_byte(2, 8'he0, 1'b0, 0);
      push_byte(2, 8'he1, 1'b1, 0);
      drain("t6_drain");

      // random traffic with random UART stalls
      ready_mode = 1;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #2;
         if ($urandom_range(0, 99) < 15) begin
            int k;
            k = $urandom_range(0, NR - 1);
            if (pend_q[k].size() < 8) push_rand_pkt(k, $urandom_range(1, 4), 1'b1);
         end
      end
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete at %0t", $time);
      $fatal(1, "global timeout");
   end

endmodule
